// File: rtl/accel_pkg.sv
// Shared constants, address map and engine state type for the accelerator.
// Imported by the summation engine and the top-level core.
package accel_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 64;
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int LEN_W     = IDX_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 16'h0100;
  localparam logic [ADDR_W-1:0] ADDR_BASE   = 16'h0101;
  localparam logic [ADDR_W-1:0] ADDR_LEN    = 16'h0102;
  localparam logic [ADDR_W-1:0] ADDR_RESULT = 16'h0103;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 16'h0104;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MEM_DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } eng_state_e;

  // A window longer than the memory would revisit words; clamp it.
  function automatic logic [LEN_W-1:0] cap_len(
    input logic [LEN_W-1:0] l
  );
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

endpackage

// File: rtl/accel_sum_engine.sv
// Sequential accumulate engine: sums len_i words starting at base_i.
// Ports: start_i/base_i/len_i in, mem_addr_o/mem_data_i read port,
// busy_o/done_o/result_o status out.
module accel_sum_engine
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [IDX_W-1:0]  mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  eng_state_e        state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] result_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] acc_d;
  logic [LEN_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  ptr_d;

  // Index arithmetic wraps naturally at IDX_W bits.
  assign acc_d = acc_q + mem_data_i;
  assign cnt_d = cnt_q + 1'b1;
  assign ptr_d = ptr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            acc_q   <= '0;
            ptr_q   <= base_i;
            cnt_q   <= '0;
            len_q   <= cap_len(len_i);
          end
        end
        RUN: begin
          if (len_q == '0) begin
            // Empty window still costs one RUN cycle.
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            acc_q <= acc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (cnt_d == len_q) begin
              result_q <= acc_d;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o = ptr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;

endmodule

// File: rtl/accelerator.sv
// Memory-mapped accumulate accelerator: 64-word memory, CSR bank,
// write port, split-transaction read port with one response register.
module accelerator
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  output logic              read_rdy,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              read_data_rdy,
  output logic              read_data_vld,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]  base_q;
  logic [LEN_W-1:0]  len_q;
  logic              rvld_q;
  logic [DATA_W-1:0] rdata_q;

  logic              wr_acc;
  logic              rd_acc;
  logic              wr_mem;
  logic              rd_mem;
  logic              start;
  logic [DATA_W-1:0] rd_val;

  logic [IDX_W-1:0]  eng_addr;
  logic              eng_busy;
  logic              eng_done;
  logic [DATA_W-1:0] eng_result;

  assign write_rdy = !eng_busy;
  assign read_rdy  = !rvld_q | read_data_rdy;
  assign wr_acc    = write_en & write_rdy;
  assign rd_acc    = read_en & read_rdy;

  assign wr_mem = (write_addr[ADDR_W-1:IDX_W] == '0);
  assign rd_mem = (read_addr[ADDR_W-1:IDX_W] == '0);
  assign start  = wr_acc & (write_addr == ADDR_CTRL) & write_data[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      base_q <= '0;
      len_q  <= '0;
    end else if (wr_acc) begin
      if (wr_mem) begin
        mem_q[write_addr[IDX_W-1:0]] <= write_data;
      end else if (write_addr == ADDR_BASE) begin
        base_q <= write_data[IDX_W-1:0];
      end else if (write_addr == ADDR_LEN) begin
        len_q <= write_data[LEN_W-1:0];
      end
    end
  end

  // Reads see pre-edge state, so a same-edge write is not visible.
  always_comb begin
    rd_val = '0;
    if (rd_mem) begin
      rd_val = mem_q[read_addr[IDX_W-1:0]];
    end else begin
      case (read_addr)
        ADDR_BASE:   rd_val = DATA_W'(base_q);
        ADDR_LEN:    rd_val = DATA_W'(len_q);
        ADDR_RESULT: rd_val = eng_result;
        ADDR_STATUS: rd_val = DATA_W'({eng_done, eng_busy});
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else if (rd_acc) begin
      rvld_q  <= 1'b1;
      rdata_q <= rd_val;
    end else if (read_data_rdy) begin
      rvld_q  <= 1'b0;
    end
  end

  assign read_data_vld = rvld_q;
  assign read_data     = rdata_q;

  accel_sum_engine u_engine (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .base_i     (base_q),
    .len_i      (len_q),
    .mem_addr_o (eng_addr),
    .mem_data_i (mem_q[eng_addr]),
    .busy_o     (eng_busy),
    .done_o     (eng_done),
    .result_o   (eng_result)
  );

endmodule

// File: tb/tb_accelerator.sv
// Scoreboard testbench for the accelerator core.
// Directed vectors; read responses checked by a separate monitor.
module tb_accelerator;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        write_rdy;
  logic [15:0] write_addr;
  logic [31:0] write_data;
  logic        read_en;
  logic        read_rdy;
  logic [15:0] read_addr;
  logic        read_data_rdy;
  logic        read_data_vld;
  logic [31:0] read_data;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb [$];

  accelerator dut (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_en       (read_en),
    .read_rdy      (read_rdy),
    .read_addr     (read_addr),
    .read_data_rdy (read_data_rdy),
    .read_data_vld (read_data_vld),
    .read_data     (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  // A handshake completes at the posedge following a negedge with vld&rdy.
  always @(negedge clk) begin
    if (!rst && read_data_vld && read_data_rdy) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", read_data, 32'hxxxxxxxx);
      end else begin
        check("rsp_data", read_data, sb.pop_front());
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    int n = 0;
    while (!write_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!write_rdy) check("wr_rdy_timeout", 32'(write_rdy), 32'd1);
    write_en = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] exp);
    int n = 0;
    read_data_rdy = 1'b1;
    while (!read_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!read_rdy) check("rd_rdy_timeout", 32'(read_rdy), 32'd1);
    sb.push_back(exp);
    read_en = 1'b1;
    read_addr = a;
    @(posedge clk); #1;
    read_en = 1'b0;
    check("rd_latency_vld", 32'(read_data_vld), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (!write_rdy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    rst = 1'b1;
    write_en = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_en = 1'b0;
    read_addr = '0;
    read_data_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_write_rdy", 32'(write_rdy), 32'd1);
    check("rst_read_rdy", 32'(read_rdy), 32'd1);
    check("rst_vld", 32'(read_data_vld), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    do_read(16'h0104, 32'h0);
    do_read(16'h0003, 32'h0);

    // Basic window sum
    do_write(16'h0000, 32'd1);
    do_write(16'h0001, 32'd2);
    do_write(16'h0002, 32'd3);
    do_write(16'h0003, 32'd4);
    do_write(16'h0101, 32'd0);
    do_write(16'h0102, 32'd4);
    do_write(16'h0100, 32'd1);
    wait_idle("run_len4_cycles", 4);
    do_read(16'h0104, 32'h2);
    do_read(16'h0103, 32'h0000000A);
    do_read(16'h0100, 32'h0);

    // Index and sum wrap
    do_write(16'h003E, 32'hFFFFFFFF);
    do_write(16'h003F, 32'd2);
    do_write(16'h0000, 32'd5);
    do_write(16'h0101, 32'h3E);
    do_write(16'h0102, 32'd3);
    do_write(16'h0100, 32'd1);
    wait_idle("run_len3_cycles", 3);
    do_read(16'h0103, 32'h6);
    do_read(16'h0101, 32'h3E);
    do_read(16'h0102, 32'h3);

    // Empty window
    do_write(16'h0102, 32'd0);
    do_write(16'h0100, 32'd1);
    wait_idle("run_len0_cycles", 1);
    do_read(16'h0103, 32'h0);
    do_read(16'h0104, 32'h2);

    // Backpressure and back-to-back throughput
    @(posedge clk); #1;
    read_data_rdy = 1'b0;
    sb.push_back(32'd2);
    read_en = 1'b1;
    read_addr = 16'h0001;
    @(posedge clk); #1;
    read_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_read_rdy", 32'(read_rdy), 32'd0);
      check("bp_hold_data", read_data, 32'd2);
      @(posedge clk); #1;
    end
    sb.push_back(32'd3);
    read_data_rdy = 1'b1;
    read_en = 1'b1;
    read_addr = 16'h0002;
    @(posedge clk); #1;
    read_en = 1'b0;
    check("b2b_vld", 32'(read_data_vld), 32'd1);
    check("b2b_data", read_data, 32'd3);

    // LEN 200 -> low 7 bits 72 -> capped to 64; sum of whole memory
    do_write(16'h0102, 32'd200);
    do_read(16'h0102, 32'h48);
    do_write(16'h0100, 32'd1);
    wait_idle("run_cap_cycles", 64);
    do_read(16'h0103, 32'd15);

    // Ignored writes and unmapped reads
    do_write(16'h0200, 32'h12345678);
    do_write(16'h0103, 32'hDEADBEEF);
    do_read(16'h0200, 32'h0);
    do_read(16'h0103, 32'd15);

    // Same-edge write and read of one address
    sb.push_back(32'h0);
    write_en = 1'b1;
    write_addr = 16'h0005;
    write_data = 32'h55;
    read_en = 1'b1;
    read_addr = 16'h0005;
    @(posedge clk); #1;
    write_en = 1'b0;
    read_en = 1'b0;
    do_read(16'h0005, 32'h55);

    // Reset mid-run
    do_write(16'h0102, 32'd64);
    do_write(16'h0100, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("run_busy_pre_rst", 32'(write_rdy), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_write_rdy", 32'(write_rdy), 32'd1);
    check("rst_mid_vld", 32'(read_data_vld), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(16'h0104, 32'h0);
    do_read(16'h0103, 32'h0);
    do_read(16'h0005, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
